cc_demux3_router: RTL and testbench

- Registered 1-to-3 demultiplexer with valid/ready handshaking. It is the distribution-side counterpart of the 3:1 bus selectors in the game datapath.
- Takes a data word plus a 2-bit destination selector from one producer and delivers the word to exactly one of three consumer channels, such as the video, score and sound sub-blocks.
- Each channel owns a one-entry output register and a saturating delivery counter, so a stalled consumer blocks only its own traffic.

---
 rtl/cc_demux3_router.sv | 116 +++++++++++
 tb/tb_cc_demux3_router.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_demux3_router.sv
// Registered 1-to-3 demultiplexer with valid/ready handshaking.
// Each channel has a one-entry output register and a saturating delivery counter.
module cc_demux3_router #(
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned CNTWIDTH      = 8
) (
  input  logic                     CC_DEMUX3_ROUTER_CLOCK_50,
  input  logic                     CC_DEMUX3_ROUTER_RESET_InHigh,
  input  logic [1:0]               CC_DEMUX3_ROUTER_Selector_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_DEMUX3_ROUTER_DataBus_In,
  input  logic                     CC_DEMUX3_ROUTER_Valid_In,
  output logic                     CC_DEMUX3_ROUTER_Ready_Out,
  output logic [DATAWIDTH_BUS-1:0] CC_DEMUX3_ROUTER_DataBus1_Out,
  output logic [DATAWIDTH_BUS-1:0] CC_DEMUX3_ROUTER_DataBus2_Out,
  output logic [DATAWIDTH_BUS-1:0] CC_DEMUX3_ROUTER_DataBus3_Out,
  output logic                     CC_DEMUX3_ROUTER_Valid1_Out,
  output logic                     CC_DEMUX3_ROUTER_Valid2_Out,
  output logic                     CC_DEMUX3_ROUTER_Valid3_Out,
  input  logic                     CC_DEMUX3_ROUTER_Ready1_In,
  input  logic                     CC_DEMUX3_ROUTER_Ready2_In,
  input  logic                     CC_DEMUX3_ROUTER_Ready3_In,
  output logic [CNTWIDTH-1:0]      CC_DEMUX3_ROUTER_Count1_Out,
  output logic [CNTWIDTH-1:0]      CC_DEMUX3_ROUTER_Count2_Out,
  output logic [CNTWIDTH-1:0]      CC_DEMUX3_ROUTER_Count3_Out
);

  localparam int unsigned NumCh = 3;
  localparam logic [CNTWIDTH-1:0] CntMax = '1;
  localparam logic [CNTWIDTH-1:0] CntOne = CNTWIDTH'(1);

  logic [NumCh-1:0] ready_in;
  logic [NumCh-1:0] dst_oh;
  logic             sel_full;
  logic             sel_ready;
  logic             accept;
  logic [NumCh-1:0] load;
  logic [NumCh-1:0] drain;

  logic [NumCh-1:0]         valid_q, valid_d;
  logic [DATAWIDTH_BUS-1:0] data_q  [NumCh];
  logic [DATAWIDTH_BUS-1:0] data_d  [NumCh];
  logic [CNTWIDTH-1:0]      count_q [NumCh];
  logic [CNTWIDTH-1:0]      count_d [NumCh];

  assign ready_in = {CC_DEMUX3_ROUTER_Ready3_In,
                     CC_DEMUX3_ROUTER_Ready2_In,
                     CC_DEMUX3_ROUTER_Ready1_In};

  // Selector 11 aliases onto channel 3.
  always_comb begin
    dst_oh    = 3'b100;
    sel_full  = valid_q[2];
    sel_ready = ready_in[2];
    case (CC_DEMUX3_ROUTER_Selector_In)
      2'b00: begin
        dst_oh    = 3'b001;
        sel_full  = valid_q[0];
        sel_ready = ready_in[0];
      end
      2'b01: begin
        dst_oh    = 3'b010;
        sel_full  = valid_q[1];
        sel_ready = ready_in[1];
      end
      default: begin
        dst_oh    = 3'b100;
        sel_full  = valid_q[2];
        sel_ready = ready_in[2];
      end
    endcase
  end

  // Only the addressed channel can stall the producer.
  assign CC_DEMUX3_ROUTER_Ready_Out = ~CC_DEMUX3_ROUTER_RESET_InHigh & (~sel_full | sel_ready);
  assign accept = CC_DEMUX3_ROUTER_Valid_In & CC_DEMUX3_ROUTER_Ready_Out;
  assign load   = {NumCh{accept}} & dst_oh;

  always_comb begin
    for (int n = 0; n < NumCh; n++) begin
      drain[n]   = valid_q[n] & ready_in[n];
      valid_d[n] = load[n] | (valid_q[n] & ~drain[n]);
      data_d[n]  = load[n] ? CC_DEMUX3_ROUTER_DataBus_In : data_q[n];
      count_d[n] = count_q[n];
      if (drain[n] && (count_q[n] != CntMax)) begin
        count_d[n] = count_q[n] + CntOne;
      end
    end
  end

  always_ff @(posedge CC_DEMUX3_ROUTER_CLOCK_50) begin
    if (CC_DEMUX3_ROUTER_RESET_InHigh) begin
      valid_q <= '0;
      for (int n = 0; n < NumCh; n++) begin
        data_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int n = 0; n < NumCh; n++) begin
        data_q[n]  <= data_d[n];
        count_q[n] <= count_d[n];
      end
    end
  end

  assign CC_DEMUX3_ROUTER_Valid1_Out   = valid_q[0];
  assign CC_DEMUX3_ROUTER_Valid2_Out   = valid_q[1];
  assign CC_DEMUX3_ROUTER_Valid3_Out   = valid_q[2];
  assign CC_DEMUX3_ROUTER_DataBus1_Out = data_q[0];
  assign CC_DEMUX3_ROUTER_DataBus2_Out = data_q[1];
  assign CC_DEMUX3_ROUTER_DataBus3_Out = data_q[2];
  assign CC_DEMUX3_ROUTER_Count1_Out   = count_q[0];
  assign CC_DEMUX3_ROUTER_Count2_Out   = count_q[1];
  assign CC_DEMUX3_ROUTER_Count3_Out   = count_q[2];

endmodule

// File: tb/tb_cc_demux3_router.sv
// Bench for cc_demux3_router: directed vector table, counter saturation sequences,
// and randomized traffic against a per-channel slot model.
module tb_cc_demux3_router;

  localparam int DW = 8;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic [7:0] din;
  logic       vin;
  logic [2:0] rdy;

  logic       rdy_out8, rdy_out4;
  logic [7:0] d8 [3];
  logic [7:0] d4 [3];
  logic       v8 [3];
  logic       v4 [3];
  logic [7:0] c8 [3];
  logic [3:0] c4 [3];

  int n_checks = 0;
  int n_errors = 0;

  cc_demux3_router #(.DATAWIDTH_BUS(DW), .CNTWIDTH(8)) u_dut (
    .CC_DEMUX3_ROUTER_CLOCK_50     (clk),
    .CC_DEMUX3_ROUTER_RESET_InHigh (rst),
    .CC_DEMUX3_ROUTER_Selector_In  (sel),
    .CC_DEMUX3_ROUTER_DataBus_In   (din),
    .CC_DEMUX3_ROUTER_Valid_In     (vin),
    .CC_DEMUX3_ROUTER_Ready_Out    (rdy_out8),
    .CC_DEMUX3_ROUTER_DataBus1_Out (d8[0]),
    .CC_DEMUX3_ROUTER_DataBus2_Out (d8[1]),
    .CC_DEMUX3_ROUTER_DataBus3_Out (d8[2]),
    .CC_DEMUX3_ROUTER_Valid1_Out   (v8[0]),
    .CC_DEMUX3_ROUTER_Valid2_Out   (v8[1]),
    .CC_DEMUX3_ROUTER_Valid3_Out   (v8[2]),
    .CC_DEMUX3_ROUTER_Ready1_In    (rdy[0]),
    .CC_DEMUX3_ROUTER_Ready2_In    (rdy[1]),
    .CC_DEMUX3_ROUTER_Ready3_In    (rdy[2]),
    .CC_DEMUX3_ROUTER_Count1_Out   (c8[0]),
    .CC_DEMUX3_ROUTER_Count2_Out   (c8[1]),
    .CC_DEMUX3_ROUTER_Count3_Out   (c8[2])
  );

  cc_demux3_router #(.DATAWIDTH_BUS(DW), .CNTWIDTH(4)) u_dut4 (
    .CC_DEMUX3_ROUTER_CLOCK_50     (clk),
    .CC_DEMUX3_ROUTER_RESET_InHigh (rst),
    .CC_DEMUX3_ROUTER_Selector_In  (sel),
    .CC_DEMUX3_ROUTER_DataBus_In   (din),
    .CC_DEMUX3_ROUTER_Valid_In     (vin),
    .CC_DEMUX3_ROUTER_Ready_Out    (rdy_out4),
    .CC_DEMUX3_ROUTER_DataBus1_Out (d4[0]),
    .CC_DEMUX3_ROUTER_DataBus2_Out (d4[1]),
    .CC_DEMUX3_ROUTER_DataBus3_Out (d4[2]),
    .CC_DEMUX3_ROUTER_Valid1_Out   (v4[0]),
    .CC_DEMUX3_ROUTER_Valid2_Out   (v4[1]),
    .CC_DEMUX3_ROUTER_Valid3_Out   (v4[2]),
    .CC_DEMUX3_ROUTER_Ready1_In    (rdy[0]),
    .CC_DEMUX3_ROUTER_Ready2_In    (rdy[1]),
    .CC_DEMUX3_ROUTER_Ready3_In    (rdy[2]),
    .CC_DEMUX3_ROUTER_Count1_Out   (c4[0]),
    .CC_DEMUX3_ROUTER_Count2_Out   (c4[1]),
    .CC_DEMUX3_ROUTER_Count3_Out   (c4[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one slot per channel plus an unbounded delivery tally.
  bit         m_full [3];
  logic [7:0] m_data [3];
  int         m_cnt  [3];
  bit         m_hold;

  function automatic int dst_of(input logic [1:0] s);
    if (s == 2'd0) return 0;
    if (s == 2'd1) return 1;
    return 2;
  endfunction

  function automatic bit m_ready();
    int d;
    d = dst_of(sel);
    return !rst && (!m_full[d] || rdy[d]);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    for (int n = 0; n < 3; n++) begin
      m_full[n] = 0;
      m_data[n] = '0;
      m_cnt[n]  = 0;
    end
    m_hold = 0;
  end

  always @(posedge clk) begin
    bit acc;
    int d;
    if (rst) begin
      for (int n = 0; n < 3; n++) begin
        m_full[n] = 0;
        m_data[n] = '0;
        m_cnt[n]  = 0;
      end
      m_hold = 0;
    end else begin
      d      = dst_of(sel);
      acc    = vin && (!m_full[d] || rdy[d]);
      m_hold = vin && !acc;
      for (int n = 0; n < 3; n++) begin
        if (m_full[n] && rdy[n]) begin
          m_cnt[n]++;
          m_full[n] = 0;
        end
      end
      if (acc) begin
        m_full[d] = 1;
        m_data[d] = din;
      end
    end
  end

  task automatic check_model();
    chk("ready_out", 32'(rdy_out8), 32'(m_ready()));
    chk("ready_out_c4", 32'(rdy_out4), 32'(m_ready()));
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("valid%0d", n + 1), 32'(v8[n]), 32'(m_full[n]));
      chk($sformatf("data%0d", n + 1), 32'(d8[n]), 32'(m_data[n]));
      chk($sformatf("count%0d", n + 1), 32'(c8[n]), 32'(sat(m_cnt[n], 255)));
      chk($sformatf("count%0d_c4", n + 1), 32'(c4[n]), 32'(sat(m_cnt[n], 15)));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       vin;
    logic [1:0] sel;
    logic [7:0] data;
    logic [2:0] rdy;
    logic       e_rdy;
    logic [2:0] e_v;
    logic [7:0] e_d1, e_d2, e_d3;
    int         e_c1, e_c2, e_c3;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //            rst vin sel    data   rdy     e_rdy e_v     d1     d2     d3    c1 c2 c3
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 3'b000, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'hA5, 3'b001, 1'b1, 3'b001, 8'hA5, 8'h00, 8'h00, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b001, 1'b1, 3'b000, 8'hA5, 8'h00, 8'h00, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 2'd3, 8'h3C, 3'b000, 1'b1, 3'b100, 8'hA5, 8'h00, 8'h3C, 1, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h11, 3'b000, 1'b1, 3'b110, 8'hA5, 8'h11, 8'h3C, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 2'd1, 8'h22, 3'b000, 1'b0, 3'b110, 8'hA5, 8'h11, 8'h3C, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 2'd0, 8'h33, 3'b000, 1'b1, 3'b111, 8'h33, 8'h11, 8'h3C, 1, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 2'd1, 8'h44, 3'b010, 1'b1, 3'b111, 8'h33, 8'h44, 8'h3C, 1, 1, 0};
    tbl[8]  = '{1'b0, 1'b1, 2'd1, 8'h55, 3'b010, 1'b1, 3'b111, 8'h33, 8'h55, 8'h3C, 1, 2, 0};
    tbl[9]  = '{1'b0, 1'b1, 2'd1, 8'h66, 3'b010, 1'b1, 3'b111, 8'h33, 8'h66, 8'h3C, 1, 3, 0};
    tbl[10] = '{1'b0, 1'b0, 2'd1, 8'h00, 3'b010, 1'b1, 3'b101, 8'h33, 8'h66, 8'h3C, 1, 4, 0};
    tbl[11] = '{1'b0, 1'b1, 2'd1, 8'h77, 3'b000, 1'b1, 3'b111, 8'h33, 8'h77, 8'h3C, 1, 4, 0};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 8'h88, 3'b100, 1'b1, 3'b111, 8'h33, 8'h77, 8'h88, 1, 4, 1};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 8'hFF, 3'b111, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 3'b111, 1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0};
  end

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic [2:0] rd);
    rst = r;
    vin = v;
    sel = s;
    din = d;
    rdy = rd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b000);
    @(posedge clk);
    #1;

    // Directed vectors: ready checked mid-cycle, registers checked just after the edge.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].vin, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      #4;
      chk($sformatf("v%0d_ready_out", i), 32'(rdy_out8), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valids", i), 32'({v8[2], v8[1], v8[0]}), 32'(tbl[i].e_v));
      chk($sformatf("v%0d_data1", i), 32'(d8[0]), 32'(tbl[i].e_d1));
      chk($sformatf("v%0d_data2", i), 32'(d8[1]), 32'(tbl[i].e_d2));
      chk($sformatf("v%0d_data3", i), 32'(d8[2]), 32'(tbl[i].e_d3));
      chk($sformatf("v%0d_count1", i), 32'(c8[0]), 32'(tbl[i].e_c1));
      chk($sformatf("v%0d_count2", i), 32'(c8[1]), 32'(tbl[i].e_c2));
      chk($sformatf("v%0d_count3", i), 32'(c8[2]), 32'(tbl[i].e_c3));
      chk($sformatf("v%0d_count1_c4", i), 32'(c4[0]), 32'(tbl[i].e_c1));
    end

    // 20 back-to-back words to ch1: 4-bit counter pins at 15, 8-bit reaches 20.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 2'd0, 8'(i + 1), 3'b001);
      #4;
      chk("sat_stream_ready", 32'(rdy_out8), 32'd1);
      @(posedge clk);
      #1;
      if (i == 15) chk("sat_c4_at_15", 32'(c4[0]), 32'd15);
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b001);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_c4_count1", 32'(c4[0]), 32'd15);
    chk("sat_c8_count1", 32'(c8[0]), 32'd20);
    chk("sat_valid1", 32'(v8[0]), 32'd0);
    chk("sat_data1", 32'(d8[0]), 32'd20);

    // 260 words to ch3 via selector 11: 8-bit counter pins at 255.
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 1'b1, 2'd3, 8'(i), 3'b100);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 2'd3, 8'h00, 3'b100);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_c8_count3", 32'(c8[2]), 32'd255);
    chk("sat_c4_count3", 32'(c4[2]), 32'd15);
    chk("sat_count2_untouched", 32'(c8[1]), 32'd0);

    // Randomized traffic; a stalled offer is held until accepted.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      rdy = 3'($urandom);
      if (!m_hold) begin
        vin = ($urandom_range(0, 3) != 0);
        sel = 2'($urandom);
        din = 8'($urandom);
      end
      #4;
      check_model();
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
